fetch_stage: RTL
================

Name: fetch_stage

Overview:
- Instruction-fetch stage of the 16-bit pipelined core. It owns the PC register and the IF/ID pipeline register.
- It drives the instruction-memory address and accepts a ready-qualified instruction word.
- It consumes the next-PC/taken decision that branch resolution produces in ID, and feeds PC+2 and the instruction into ID, where they become branch resolution's PC input.
- It handles pipeline stall, wrong-path flush, memory wait and HLT freeze.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- HALT_OPCODE, 4'hF, opcode field (instr[15:12]) that freezes fetch.
- NOP_INSTR, 16'h0000, instruction word placed in IF/ID on a bubble.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- stall  input  1  hazard unit: hold PC and IF/ID this cycle.
- branch_taken  input  1  ID-stage branch resolved taken (redirect).
- branch_target  input  16  redirect PC, valid when branch_taken=1.
- imem_addr  output  16  instruction address; equals pc combinationally.
- imem_instr  input  16  instruction word for imem_addr.
- imem_ready  input  1  imem_instr valid this cycle (multi-cycle memory allowed).
- if_id_instr  output  16  registered instruction to ID.
- if_id_pc_plus2  output  16  registered PC+2 of that instruction.
- if_id_valid  output  1  1 = real instruction, 0 = bubble.
- halted  output  1  1 while in HALT state.
- fetch_count  output  16  number of valid instructions written to IF/ID; saturates at 16'hFFFF.

Behaviour:
- Reset (async, any time, including mid-wait):
  - pc=RESET_PC, state=RUN.
  - if_id_instr=NOP_INSTR, if_id_pc_plus2=16'h0000, if_id_valid=0.
  - halted=0, fetch_count=0.
- States: RUN, HALT. halted = (state==HALT).
- Per-cycle priority in RUN, highest first:
  1. stall=1: pc, IF/ID and fetch_count hold. branch_taken is ignored (a stalled ID has not resolved its branch).
  2. branch_taken=1: pc<=branch_target; IF/ID <= bubble (instr=NOP_INSTR, valid=0). The word fetched this cycle is wrong-path and is discarded even if imem_ready=1. If the fetched word carries HALT_OPCODE, no halt occurs.
  3. imem_ready=0: pc holds; IF/ID <= bubble.
  4. imem_ready=1 with opcode != HALT_OPCODE: pc<=pc+2 (16-bit wrap, 16'hFFFE -> 16'h0000); IF/ID <= {imem_instr, pc+2, valid=1}; fetch_count increments.
  5. imem_ready=1 with opcode == HALT_OPCODE: pc holds at the HLT address; IF/ID <= {imem_instr, pc+2, valid=1}; fetch_count increments; state<=HALT.
- HALT state:
  - pc frozen; no further fetch.
  - If not stalled, IF/ID <= bubble every cycle, so HLT is passed to ID exactly once.
  - If stall=1: hold everything, remain in HALT.
  - If branch_taken=1 and stall=0: pc<=branch_target, IF/ID <= bubble, state<=RUN. This covers an HLT fetched under a not-yet-resolved older branch.
- Latency:
  - The instruction at pc appears on if_id_* one edge after imem_ready=1.
  - A redirect takes effect on imem_addr one edge after branch_taken.
- pc+2 uses a single 16-bit adder; carry is dropped.
- fetch_count holds at 16'hFFFF once reached.
- imem_addr may change while the memory is mid-access (redirect or reset). The memory must restart on an address change; this block never holds a stale request.

Decomposition:
- Shared core package: RESET_PC, HALT_OPCODE, NOP_INSTR, opcode field position [15:12], state encoding (RUN=1'b0, HALT=1'b1).
- Sub-module: if_id_reg, the IF/ID pipeline register with async reset, write-enable (hold) and bubble-insert inputs. It is reused when later stages grow flush logic.
- The PC register and FSM stay in fetch_stage.

Test Plan:
- Reset, then imem_ready=1 streaming 0x1111, 0x2222, 0x3333 -> imem_addr 0x0000, 0x0002, 0x0004; if_id_pc_plus2 0x0002, 0x0004, 0x0006; valid=1 each cycle; fetch_count=3.
- At pc=0x0004 assert branch_taken with branch_target=0x0040 and imem_ready=1 -> next cycle pc=0x0040, if_id_valid=0, fetch_count unchanged.
- Stall for 2 cycles with branch_taken=1 at pc=0x0008 -> pc, if_id_* and fetch_count unchanged both cycles; no redirect.
- imem_ready=0 for 3 cycles at pc=0x0010 -> pc holds 0x0010; 3 bubbles; 4th cycle ready with 0x5555 -> IF/ID={0x5555, 0x0012, valid=1}.
- Fetch 0xF000 at pc=0x0020 -> IF/ID={0xF000, 0x0022, valid=1} once; halted=1; pc stays 0x0020; bubbles after. Then branch_taken with target 0x0100 -> halted=0, pc=0x0100.
- Wrap: pc=0xFFFE fetching 0x1234 -> pc=0x0000, if_id_pc_plus2=0x0000. Also assert rst mid-wait (imem_ready=0) -> all outputs at reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: default reset PC,
// HLT opcode, bubble instruction, opcode field position and FSM encoding.
package fetch_stage_pkg;

  localparam logic [15:0] RESET_PC_DEF    = 16'h0000;
  localparam logic [3:0]  HALT_OPCODE_DEF = 4'hF;
  localparam logic [15:0] NOP_INSTR_DEF   = 16'h0000;

  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } fetch_state_e;

  function automatic logic [3:0] opcode_of(input logic [15:0] instr);
    return instr[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory bus between the fetch stage (master) and memory (slave).
//   imem_addr  : fetch address, driven combinationally from the PC
//   imem_instr : instruction word for imem_addr
//   imem_ready : imem_instr valid this cycle
interface fetch_stage_if;
  logic [15:0] imem_addr;
  logic [15:0] imem_instr;
  logic        imem_ready;

  modport master (output imem_addr, input imem_instr, input imem_ready);
  modport slave  (input imem_addr, output imem_instr, output imem_ready);
endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register.
//   clk, rst      : clock, async active-high reset
//   we            : 1 = update this cycle, 0 = hold
//   bubble        : with we, load NOP_INSTR / valid=0 instead of the inputs
//   instr_in      : instruction to latch
//   pc_plus2_in   : PC+2 of that instruction
//   instr, pc_plus2, valid : registered outputs to ID
module if_id_reg #(
  parameter logic [15:0] NOP_INSTR = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic        bubble,
  input  logic [15:0] instr_in,
  input  logic [15:0] pc_plus2_in,
  output logic [15:0] instr,
  output logic [15:0] pc_plus2,
  output logic        valid
);

  // A bubble leaves pc_plus2 untouched; ID ignores it while valid=0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr    <= NOP_INSTR;
      pc_plus2 <= 16'h0000;
      valid    <= 1'b0;
    end else if (we) begin
      if (bubble) begin
        instr <= NOP_INSTR;
        valid <= 1'b0;
      end else begin
        instr    <= instr_in;
        pc_plus2 <= pc_plus2_in;
        valid    <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, the RUN/HALT FSM, the fetch counter
// and the IF/ID register.
//   clk, rst       : clock, async active-high reset
//   stall          : hold PC, IF/ID and fetch_count
//   branch_taken   : redirect to branch_target (ignored while stalled)
//   imem           : instruction-memory bus (master side)
//   if_id_*        : registered instruction, its PC+2 and valid flag to ID
//   halted         : 1 while in HALT
//   fetch_count    : valid instructions written to IF/ID, saturating
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [15:0] RESET_PC    = RESET_PC_DEF,
  parameter logic [3:0]  HALT_OPCODE = HALT_OPCODE_DEF,
  parameter logic [15:0] NOP_INSTR   = NOP_INSTR_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 branch_taken,
  input  logic [15:0]          branch_target,
  fetch_stage_if.master        imem,
  output logic [15:0]          if_id_instr,
  output logic [15:0]          if_id_pc_plus2,
  output logic                 if_id_valid,
  output logic                 halted,
  output logic [15:0]          fetch_count
);

  fetch_state_e state, state_n;
  logic [15:0]  pc, pc_n, pc_plus2;
  logic         ifid_we, ifid_bubble, count_inc;

  assign pc_plus2       = pc + 16'd2;
  assign imem.imem_addr = pc;
  assign halted         = (state == ST_HALT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_RUN;
      pc          <= RESET_PC;
      fetch_count <= 16'h0000;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      if (count_inc && (fetch_count != 16'hFFFF))
        fetch_count <= fetch_count + 16'd1;
    end
  end

  always_comb begin
    state_n     = state;
    pc_n        = pc;
    ifid_we     = 1'b0;
    ifid_bubble = 1'b0;
    count_inc   = 1'b0;
    case (state)
      ST_RUN: begin
        if (stall) begin
          // Hold everything; an unresolved branch in a stalled ID is not real.
        end else if (branch_taken) begin
          // Word fetched this cycle is wrong-path, including a wrong-path HLT.
          pc_n        = branch_target;
          ifid_we     = 1'b1;
          ifid_bubble = 1'b1;
        end else if (!imem.imem_ready) begin
          ifid_we     = 1'b1;
          ifid_bubble = 1'b1;
        end else begin
          ifid_we   = 1'b1;
          count_inc = 1'b1;
          if (opcode_of(imem.imem_instr) == HALT_OPCODE)
            state_n = ST_HALT;   // PC stays on the HLT address
          else
            pc_n = pc_plus2;
        end
      end
      ST_HALT: begin
        if (!stall) begin
          ifid_we     = 1'b1;
          ifid_bubble = 1'b1;
          // An older branch resolving taken releases a speculatively fetched HLT.
          if (branch_taken) begin
            pc_n    = branch_target;
            state_n = ST_RUN;
          end
        end
      end
      default: state_n = ST_RUN;
    endcase
  end

  if_id_reg #(.NOP_INSTR(NOP_INSTR)) u_if_id_reg (
    .clk         (clk),
    .rst         (rst),
    .we          (ifid_we),
    .bubble      (ifid_bubble),
    .instr_in    (imem.imem_instr),
    .pc_plus2_in (pc_plus2),
    .instr       (if_id_instr),
    .pc_plus2    (if_id_pc_plus2),
    .valid       (if_id_valid)
  );

endmodule
